// File: rtl/fifo_wr_arb_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_if: requester/FIFO-side bundle for the two-port write arbiter.
//   req0/din0, req1/din1 : requester words, held until taken
//   data_count           : occupancy of the 8-entry FIFO (0..8)
//   gnt0/gnt1            : current owner of the FIFO write port
//   wr_en/dout           : FIFO write strobe and write data
// master = requester/FIFO side, slave = arbiter.
// -----------------------------------------------------------------------------
interface fifo_wr_arb_if #(
  parameter int unsigned DW = 32
);
  logic          req0;
  logic [DW-1:0] din0;
  logic          req1;
  logic [DW-1:0] din1;
  logic [3:0]    data_count;
  logic          gnt0;
  logic          gnt1;
  logic          wr_en;
  logic [DW-1:0] dout;

  modport master (
    output req0, din0, req1, din1, data_count,
    input  gnt0, gnt1, wr_en, dout
  );

  modport slave (
    input  req0, din0, req1, din1, data_count,
    output gnt0, gnt1, wr_en, dout
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb: two-requester write arbiter in front of an 8-entry FIFO.
// Grants are held for up to BURST beats while the other side waits, handed
// over without a gap cycle, and ties from IDLE go to the requester that was
// not granted last. Writes are suppressed whenever the FIFO reports full.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : fifo_wr_arb_if.slave (req/din per requester, data_count in;
//              gnt0/gnt1/wr_en/dout out)
// gnt0/gnt1 decode the state register; wr_en/dout are combinational so a
// beat can happen in the first granted cycle.
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int unsigned BURST = 4,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  fifo_wr_arb_if.slave  bus
);

  localparam int unsigned CW       = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] burst_cnt_nxt;
  logic          last;
  logic          last_nxt;

  logic          full_c;
  logic          beat_c;
  logic          at_end_c;
  logic [DW-1:0] dout_c;

  // Full is judged from occupancy alone; a same-cycle read does not help.
  always_comb begin
    full_c   = (bus.data_count == 4'd8);
    beat_c   = ~full_c & (((state == GNT0) & bus.req0) |
                          ((state == GNT1) & bus.req1));
    at_end_c = (burst_cnt == CNT_LAST);
  end

  // State, burst counter and tie-break history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last      <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      last      <= last_nxt;
    end
  end

  // Next-state: grant selection, burst handover and counter maintenance.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    last_nxt      = last;

    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (bus.req0) begin
          state_nxt = GNT0;
        end else if (bus.req1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!bus.req0) begin
          state_nxt = bus.req1 ? GNT1 : IDLE;
        end else if (beat_c && at_end_c && bus.req1) begin
          state_nxt = GNT1;
        end
      end
      GNT1: begin
        if (!bus.req1) begin
          state_nxt = bus.req0 ? GNT0 : IDLE;
        end else if (beat_c && at_end_c && bus.req0) begin
          state_nxt = GNT0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Counter restarts on any owner change; otherwise it wraps at BURST-1.
    if (state_nxt != state) begin
      burst_cnt_nxt = '0;
    end else if (beat_c) begin
      burst_cnt_nxt = at_end_c ? '0 : burst_cnt + CW'(1);
    end

    if (state_nxt == GNT0) begin
      last_nxt = 1'b0;
    end else if (state_nxt == GNT1) begin
      last_nxt = 1'b1;
    end
  end

  always_comb begin
    dout_c = (state == GNT1) ? bus.din1 : bus.din0;
  end

  assign bus.gnt0  = (state == GNT0);
  assign bus.gnt1  = (state == GNT1);
  assign bus.wr_en = beat_c;
  assign bus.dout  = dout_c;

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;
  localparam int unsigned BURST = 4;
  localparam int unsigned DW    = 32;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  fifo_wr_arb_if #(.DW(DW)) bus ();

  fifo_wr_arb #(.BURST(BURST), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int issued  = 0;
  int written = 0;
  int left[2];
  bit rnd = 1'b0;

  // Reference: owner (-1 none, 0, 1), beats taken in the current tenure, last owner.
  int m_owner;
  int m_beats;
  bit m_last;

  logic          s_gnt0, s_gnt1, s_wr;
  logic [DW-1:0] s_dout;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = 1'b1;
  endfunction

  function automatic void model_step(input bit r0, input bit r1, input bit full, output bit beat);
    int nxt;
    bit mine, other;
    beat = !full && ((m_owner == 0 && r0) || (m_owner == 1 && r1));
    nxt  = m_owner;
    if (m_owner < 0) begin
      if (r0 && r1)  nxt = m_last ? 0 : 1;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
    end else begin
      mine  = (m_owner == 0) ? r0 : r1;
      other = (m_owner == 0) ? r1 : r0;
      if (!mine) begin
        nxt = other ? 1 - m_owner : -1;
      end else if (beat) begin
        m_beats++;
        if (other && (m_beats % int'(BURST)) == 0) nxt = 1 - m_owner;
      end
    end
    if (nxt != m_owner) begin
      m_beats = 0;
      if (nxt >= 0) m_last = (nxt == 1);
    end
    m_owner = nxt;
  endfunction

  task automatic present(input int x);
    if (x == 0) begin
      bus.din0 = $urandom;
      bus.req0 = 1'b1;
    end else begin
      bus.din1 = $urandom;
      bus.req1 = 1'b1;
    end
    issued++;
    left[x]--;
  endtask

  // Requester x after a possible take: reissue, drop, or (random mode) raise.
  task automatic requester(input int x, input bit taken);
    bit busy;
    busy = (x == 0) ? bus.req0 : bus.req1;
    if (taken) begin
      if (left[x] > 0 && (!rnd || $urandom_range(0, 1) == 1)) present(x);
      else if (x == 0) bus.req0 = 1'b0;
      else bus.req1 = 1'b0;
    end else if (!busy && rnd && left[x] > 0 && $urandom_range(0, 3) == 0) begin
      present(x);
    end
  endtask

  // One clock: check at negedge against the model, then let requesters react.
  task automatic cycle();
    bit beat, t0, t1;
    logic [DW-1:0] exp_dout;
    @(negedge clk);
    s_gnt0 = bus.gnt0;
    s_gnt1 = bus.gnt1;
    s_wr   = bus.wr_en;
    s_dout = bus.dout;
    exp_dout = (m_owner == 1) ? bus.din1 : bus.din0;
    chk("gnt0", s_gnt0, m_owner == 0);
    chk("gnt1", s_gnt1, m_owner == 1);
    chk("dout", s_dout, exp_dout);
    model_step(bus.req0, bus.req1, bus.data_count == 4'd8, beat);
    chk("wr_en", s_wr, beat);
    chk("wr_while_full", s_wr && (bus.data_count == 4'd8), 0);
    chk("both_granted", s_gnt0 && s_gnt1, 0);
    t0 = s_wr && s_gnt0;
    t1 = s_wr && s_gnt1;
    if (s_wr) written++;
    @(posedge clk);
    #1;
    requester(0, t0);
    requester(1, t1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_dout", bus.dout, bus.din0);
    model_reset();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    left[0] = 0;
    left[1] = 0;
    bus.data_count = 4'd0;
    for (int i = 0; i < 64 && (bus.req0 || bus.req1); i++) cycle();
    chk("drain_timeout", bus.req0 || bus.req1, 0);
    cycle();
    cycle();
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.din0 = 32'hA5A5_0001;
    bus.din1 = 32'h5A5A_0002;
    bus.data_count = 4'd0;
    left[0] = 0;
    left[1] = 0;
    do_reset();
    chk("rst_dout_lit", bus.dout, 32'hA5A5_0001);
    release_reset();

    // Both requesting continuously: alternating bursts of BURST, no gap.
    left[0] = 100;
    left[1] = 100;
    present(0);
    present(1);
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (k >= 1) begin
        chk("tie_gnt0", s_gnt0, ((k - 1) / 4) % 2 == 0);
        chk("tie_gnt1", s_gnt1, ((k - 1) / 4) % 2 == 1);
        chk("tie_wr", s_wr, 1);
      end
    end
    drain();

    // Single requester, 10 words: no grant change across counter wraps.
    begin
      int wr_cnt, g1_cnt;
      wr_cnt = 0;
      g1_cnt = 0;
      left[0] = 10;
      bus.data_count = 4'd3;
      present(0);
      for (int k = 0; k < 12; k++) begin
        cycle();
        if (s_wr) wr_cnt++;
        if (s_gnt1) g1_cnt++;
        if (k >= 1 && k <= 10) chk("solo_gnt0", s_gnt0, 1);
      end
      chk("solo_words", wr_cnt, 10);
      chk("solo_no_gnt1", g1_cnt, 0);
    end
    drain();

    // Full stall during gnt1: grant and burst position held.
    left[1] = 20;
    present(1);
    cycle();
    cycle();
    chk("stall_pre_gnt1", s_gnt1, 1);
    chk("stall_pre_wr", s_wr, 1);
    bus.data_count = 4'd8;
    left[0] = 20;
    present(0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_gnt1", s_gnt1, 1);
      chk("stall_wr", s_wr, 0);
    end
    bus.data_count = 4'd7;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("resume_gnt1", s_gnt1, k < 3);
      chk("resume_gnt0", s_gnt0, k == 3);
      chk("resume_wr", s_wr, 1);
    end
    drain();

    // req0 withdrawn while req1 waits: immediate handover, fresh burst.
    left[0] = 100;
    left[1] = 100;
    present(0);
    cycle();
    cycle();
    present(1);
    cycle();
    chk("drop_pre_gnt0", s_gnt0, 1);
    bus.req0 = 1'b0;
    left[0] = 0;
    issued--;
    cycle();
    chk("drop_gnt0_nowr", s_wr, 0);
    cycle();
    chk("drop_gnt1", s_gnt1, 1);
    chk("drop_wr", s_wr, 1);
    left[0] = 100;
    present(0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("drop_burst_gnt1", s_gnt1, k < 3);
      chk("drop_burst_gnt0", s_gnt0, k == 3);
    end
    drain();

    // Reset mid-burst after two beats of gnt0; next tie goes to req0.
    left[0] = 100;
    present(0);
    cycle();
    cycle();
    cycle();
    chk("mid_gnt0", s_gnt0, 1);
    do_reset();
    left[1] = 100;
    present(1);
    release_reset();
    cycle();
    chk("post_rst_idle", s_gnt0 || s_gnt1, 0);
    cycle();
    chk("post_rst_tie_gnt0", s_gnt0, 1);
    chk("post_rst_tie_wr", s_wr, 1);
    drain();

    // Random traffic with frequent full stalls.
    rnd = 1'b1;
    left[0] = 4000;
    left[1] = 4000;
    for (int k = 0; k < 10000; k++) begin
      bus.data_count = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 7));
      cycle();
    end
    drain();
    chk("word_count", written, issued);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
